// File: rtl/axis_ipv4_frame_filter.sv
// AXI-Stream ingress filter: forwards well-formed IPv4 Ethernet frames through a
// single output register and silently consumes everything else, with pass/drop counters.
module axis_ipv4_frame_filter #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  input  logic                  enable,
  output logic [31:0]           stat_pass_frames,
  output logic [31:0]           stat_drop_frames
);

  typedef enum logic [1:0] {
    ST_HEAD = 2'd0,
    ST_PASS = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [1:0]            r_rst_sync;
  logic                  w_rst_n;
  logic [DATA_WIDTH-1:0] r_m_tdata;
  logic                  r_m_tvalid;
  logic                  r_m_tlast;
  logic [31:0]           r_pass_cnt;
  logic [31:0]           r_drop_cnt;

  logic                  w_accept;
  logic                  w_head_ok;
  logic                  w_load;
  logic                  w_pass_inc;
  logic                  w_drop_inc;
  logic [7:0]            w_byte12;
  logic [7:0]            w_byte13;
  logic [7:0]            w_byte14;
  logic                  w_unused_keep;

  // Reset asserts immediately but releases two clocks after rst_n rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_sync <= 2'b00;
    end else begin
      r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_sync[1];

  assign w_byte12 = s_axis_tdata[12*8 +: 8];
  assign w_byte13 = s_axis_tdata[13*8 +: 8];
  assign w_byte14 = s_axis_tdata[14*8 +: 8];

  assign w_head_ok = enable &&
                     (w_byte12 == 8'h08) && (w_byte13 == 8'h00) &&
                     (w_byte14[7:4] == 4'd4) && (w_byte14[3:0] >= 4'd5) &&
                     (&s_axis_tkeep[19:0]);

  assign w_unused_keep = ^s_axis_tkeep[KEEP_WIDTH-1:20];

  // Discarded beats never touch the output register, so DROP never back-pressures.
  assign s_axis_tready = w_rst_n &&
                         ((r_state == ST_DROP) || !r_m_tvalid || m_axis_tready);
  assign w_accept      = s_axis_tvalid && s_axis_tready;

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state <= ST_HEAD;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_pass_inc  = 1'b0;
    w_drop_inc  = 1'b0;
    case (r_state)
      ST_HEAD: begin
        if (w_accept) begin
          if (w_head_ok) begin
            w_load     = 1'b1;
            w_pass_inc = s_axis_tlast;
            if (!s_axis_tlast) w_state_nxt = ST_PASS;
          end else begin
            w_drop_inc = 1'b1;
            if (!s_axis_tlast) w_state_nxt = ST_DROP;
          end
        end
      end
      ST_PASS: begin
        if (w_accept) begin
          w_load = 1'b1;
          if (s_axis_tlast) begin
            w_pass_inc  = 1'b1;
            w_state_nxt = ST_HEAD;
          end
        end
      end
      ST_DROP: begin
        if (w_accept && s_axis_tlast) w_state_nxt = ST_HEAD;
      end
      default: begin
        w_state_nxt = ST_HEAD;
      end
    endcase
  end

  // A load can only happen when the register is empty or draining this cycle.
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_m_tdata  <= '0;
      r_m_tlast  <= 1'b0;
      r_m_tvalid <= 1'b0;
    end else if (w_load) begin
      r_m_tdata  <= s_axis_tdata;
      r_m_tlast  <= s_axis_tlast;
      r_m_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      r_m_tvalid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_pass_cnt <= 32'd0;
      r_drop_cnt <= 32'd0;
    end else begin
      if (w_pass_inc) r_pass_cnt <= r_pass_cnt + 32'd1;
      if (w_drop_inc) r_drop_cnt <= r_drop_cnt + 32'd1;
    end
  end

  assign m_axis_tdata     = r_m_tdata;
  assign m_axis_tvalid    = r_m_tvalid;
  assign m_axis_tlast     = r_m_tlast;
  assign stat_pass_frames = r_pass_cnt;
  assign stat_drop_frames = r_drop_cnt;

endmodule
